// File: rtl/ps2_key_decoder.sv
// ---------------------------------------------------------------------------
// ps2_key_decoder
//   Receives PS/2 Set-2 scan codes from the keyboard pins and maintains a live
//   held/released bitmap of six game keys for the sprite renderer. The last
//   good byte and a frame-error strobe are exposed for debug.
//
// Ports
//   i_clk          system clock, the only clock in the block
//   i_reset        synchronous reset, active low
//   i_ps2_clk      raw PS/2 clock pin (asynchronous)
//   i_ps2_data     raw PS/2 data pin (asynchronous)
//   o_key_status   [0]=W 1D [1]=A 1C [2]=S 1B [3]=D 23 [4]=Space 29 [5]=Esc 76
//   o_scan_code    last correctly received byte
//   o_scan_valid   one-cycle pulse when o_scan_code is updated
//   o_frame_err    one-cycle pulse on parity, stop or timeout error
//
// Rx FSM states
//   state    | meaning
//   S_IDLE   | bus idle, waiting for a start bit (data=0 on a falling edge)
//   S_DATA   | shifting in 8 data bits, LSB first
//   S_PARITY | capturing the odd-parity bit
//   S_STOP   | checking stop bit and parity, then back to idle
// ---------------------------------------------------------------------------
module ps2_key_decoder #(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int TO_W           = 16
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    output logic [5:0] o_key_status,
    output logic [7:0] o_scan_code,
    output logic       o_scan_valid,
    output logic       o_frame_err
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    state_t          r_state;
    state_t          w_state_nxt;

    logic            r_clk_s1;
    logic            r_clk_s2;
    logic            r_clk_prev;
    logic            r_dat_s1;
    logic            r_dat_s2;

    logic [2:0]      r_bit_cnt;
    logic [7:0]      r_shift;
    logic            r_parity;
    logic [TO_W-1:0] r_to_cnt;
    logic            r_brk;
    logic            r_ext;

    logic            w_fall;
    logic            w_timeout;
    logic            w_stop_eval;
    logic            w_frame_good;
    logic            w_frame_bad;
    logic [5:0]      w_key_mask;

    // Two-stage synchronisers; reset to the idle bus level so that releasing
    // reset never looks like a falling edge.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_clk_s1   <= 1'b1;
            r_clk_s2   <= 1'b1;
            r_clk_prev <= 1'b1;
            r_dat_s1   <= 1'b1;
            r_dat_s2   <= 1'b1;
        end else begin
            r_clk_s1   <= i_ps2_clk;
            r_clk_s2   <= r_clk_s1;
            r_clk_prev <= r_clk_s2;
            r_dat_s1   <= i_ps2_data;
            r_dat_s2   <= r_dat_s1;
        end
    end

    assign w_fall       = r_clk_prev & ~r_clk_s2;
    // A falling edge in the same cycle as terminal count counts as activity.
    assign w_timeout    = (r_state != S_IDLE) && !w_fall && (r_to_cnt == TO_LAST);
    assign w_stop_eval  = w_fall && (r_state == S_STOP);
    assign w_frame_good = w_stop_eval && r_dat_s2 && (^{r_shift, r_parity});
    assign w_frame_bad  = (w_stop_eval && !w_frame_good) || w_timeout;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_timeout) begin
            w_state_nxt = S_IDLE;
        end else if (w_fall) begin
            case (r_state)
                S_IDLE:   if (!r_dat_s2) w_state_nxt = S_DATA;
                S_DATA:   if (r_bit_cnt == 3'd7) w_state_nxt = S_PARITY;
                S_PARITY: w_state_nxt = S_STOP;
                S_STOP:   w_state_nxt = S_IDLE;
                default:  w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_key_mask = 6'b000000;
        case (r_shift)
            8'h1D:   w_key_mask = 6'b000001;
            8'h1C:   w_key_mask = 6'b000010;
            8'h1B:   w_key_mask = 6'b000100;
            8'h23:   w_key_mask = 6'b001000;
            8'h29:   w_key_mask = 6'b010000;
            8'h76:   w_key_mask = 6'b100000;
            default: w_key_mask = 6'b000000;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_bit_cnt    <= 3'd0;
            r_shift      <= 8'h00;
            r_parity     <= 1'b0;
            r_to_cnt     <= '0;
            r_brk        <= 1'b0;
            r_ext        <= 1'b0;
            o_key_status <= 6'b000000;
            o_scan_code  <= 8'h00;
            o_scan_valid <= 1'b0;
            o_frame_err  <= 1'b0;
        end else begin
            o_scan_valid <= 1'b0;
            o_frame_err  <= 1'b0;

            if ((r_state == S_IDLE) || w_fall || w_timeout) begin
                r_to_cnt <= '0;
            end else begin
                r_to_cnt <= r_to_cnt + TO_W'(1);
            end

            if (w_fall) begin
                case (r_state)
                    S_IDLE: r_bit_cnt <= 3'd0;
                    S_DATA: begin
                        r_shift[r_bit_cnt] <= r_dat_s2;
                        r_bit_cnt          <= r_bit_cnt + 3'd1;
                    end
                    S_PARITY: r_parity <= r_dat_s2;
                    default: ;
                endcase
            end

            if (w_frame_good) begin
                o_scan_code  <= r_shift;
                o_scan_valid <= 1'b1;
                if (r_shift == 8'hF0) begin
                    r_brk <= 1'b1;
                end else if (r_shift == 8'hE0) begin
                    r_ext <= 1'b1;
                end else begin
                    // Extended codes share byte values with the game keys, so
                    // they must never touch the bitmap.
                    if (!r_ext) begin
                        if (r_brk) begin
                            o_key_status <= o_key_status & ~w_key_mask;
                        end else begin
                            o_key_status <= o_key_status | w_key_mask;
                        end
                    end
                    r_brk <= 1'b0;
                    r_ext <= 1'b0;
                end
            end

            if (w_frame_bad) begin
                o_frame_err <= 1'b1;
                r_brk       <= 1'b0;
                r_ext       <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// ---------------------------------------------------------------------------
// tb_ps2_key_decoder
//   Drives PS/2 frames into ps2_key_decoder and compares the key bitmap, scan
//   code and pulse counts against a byte-level model of the keyboard protocol.
// ---------------------------------------------------------------------------
module tb_ps2_key_decoder;

    localparam int TO = 100;
    localparam int HP = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [5:0] key_status;
    logic [7:0] scan_code;
    logic       scan_valid;
    logic       frame_err;

    ps2_key_decoder #(.TIMEOUT_CYCLES(TO), .TO_W(8)) dut (
        .i_clk        (clk),
        .i_reset      (rst_n),
        .i_ps2_clk    (ps2_clk),
        .i_ps2_data   (ps2_data),
        .o_key_status (key_status),
        .o_scan_code  (scan_code),
        .o_scan_valid (scan_valid),
        .o_frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    int         valid_cnt = 0;
    int         err_cnt   = 0;
    logic [7:0] last_code = 8'h00;

    always @(negedge clk) begin
        if (scan_valid) begin
            valid_cnt = valid_cnt + 1;
            last_code = scan_code;
        end
        if (frame_err) err_cnt = err_cnt + 1;
    end

    // byte-level protocol model
    logic [7:0] key_codes [6] = '{8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h29, 8'h76};
    logic [5:0] m_keys  = 6'b0;
    bit         m_brk   = 1'b0;
    bit         m_ext   = 1'b0;
    logic [7:0] m_code  = 8'h00;
    int         m_valid = 0;
    int         m_err   = 0;

    task automatic model_frame(input logic [7:0] b, input bit good);
        if (!good) begin
            m_err++;
            m_brk = 1'b0;
            m_ext = 1'b0;
        end else begin
            m_valid++;
            m_code = b;
            if (b == 8'hF0) m_brk = 1'b1;
            else if (b == 8'hE0) m_ext = 1'b1;
            else begin
                if (!m_ext)
                    for (int i = 0; i < 6; i++)
                        if (key_codes[i] == b) m_keys[i] = !m_brk;
                m_brk = 1'b0;
                m_ext = 1'b0;
            end
        end
    endtask

    task automatic send_bits(input logic [10:0] bits, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            ps2_data = bits[i];
            repeat (HP) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (HP) @(negedge clk);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    function automatic logic [10:0] make_frame(input logic [7:0] b, input bit flip_par,
                                               input bit bad_stop);
        logic [10:0] f;
        f[0]    = 1'b0;
        f[8:1]  = b;
        f[9]    = (~^b) ^ flip_par;
        f[10]   = ~bad_stop;
        return f;
    endfunction

    task automatic send_frame(input logic [7:0] b, input bit flip_par, input bit bad_stop);
        send_bits(make_frame(b, flip_par, bad_stop), 11);
        model_frame(b, !flip_par && !bad_stop);
        repeat (4) @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        rst_n    = 1'b0;
        repeat (n) @(negedge clk);
        rst_n    = 1'b1;
        m_keys = 6'b0;
        m_brk  = 1'b0;
        m_ext  = 1'b0;
        m_code = 8'h00;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (4) @(negedge clk);
        n_checks++;
        if (key_status !== 6'b0) begin
            n_fail++; $display("FAIL reset_keys: got %b expected %b", key_status, 6'b0);
        end
        n_checks++;
        if (scan_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid: got %b expected 0", scan_valid);
        end
        n_checks++;
        if (frame_err !== 1'b0) begin
            n_fail++; $display("FAIL reset_err: got %b expected 0", frame_err);
        end
        n_checks++;
        if (scan_code !== 8'h00) begin
            n_fail++; $display("FAIL reset_code: got %h expected 00", scan_code);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_single();
        int v0;
        v0 = valid_cnt;
        send_frame(8'h1D, 1'b0, 1'b0);
        n_checks++;
        if (valid_cnt - v0 !== 1) begin
            n_fail++; $display("FAIL single_pulses: got %0d expected 1", valid_cnt - v0);
        end
        n_checks++;
        if (last_code !== 8'h1D) begin
            n_fail++; $display("FAIL single_code: got %h expected 1d", last_code);
        end
        n_checks++;
        if (key_status !== 6'b000001) begin
            n_fail++; $display("FAIL single_keys: got %b expected 000001", key_status);
        end
    endtask

    task automatic test_sequence();
        logic [7:0] seq [4] = '{8'h1D, 8'h23, 8'hF0, 8'h1D};
        logic [5:0] exp [4] = '{6'b000001, 6'b001001, 6'b001001, 6'b001000};
        int v0;
        v0 = valid_cnt;
        for (int i = 0; i < 4; i++) begin
            send_frame(seq[i], 1'b0, 1'b0);
            n_checks++;
            if (key_status !== exp[i]) begin
                n_fail++;
                $display("FAIL seq_keys[%0d]: got %b expected %b", i, key_status, exp[i]);
            end
            n_checks++;
            if (scan_code !== seq[i]) begin
                n_fail++;
                $display("FAIL seq_code[%0d]: got %h expected %h", i, scan_code, seq[i]);
            end
        end
        n_checks++;
        if (valid_cnt - v0 !== 4) begin
            n_fail++; $display("FAIL seq_pulses: got %0d expected 4", valid_cnt - v0);
        end
    endtask

    task automatic test_parity_err();
        int v0, e0;
        v0 = valid_cnt;
        e0 = err_cnt;
        send_frame(8'h1C, 1'b1, 1'b0);
        n_checks++;
        if (err_cnt - e0 !== 1) begin
            n_fail++; $display("FAIL parity_err: got %0d expected 1", err_cnt - e0);
        end
        n_checks++;
        if (valid_cnt - v0 !== 0) begin
            n_fail++; $display("FAIL parity_valid: got %0d expected 0", valid_cnt - v0);
        end
        n_checks++;
        if (key_status !== 6'b001000) begin
            n_fail++; $display("FAIL parity_keys: got %b expected 001000", key_status);
        end
        n_checks++;
        if (scan_code !== 8'h1D) begin
            n_fail++; $display("FAIL parity_code: got %h expected 1d", scan_code);
        end
    endtask

    task automatic test_ext();
        do_reset(2);
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'h1D, 1'b0, 1'b0);
        n_checks++;
        if (key_status !== 6'b0) begin
            n_fail++; $display("FAIL ext_make: got %b expected 000000", key_status);
        end
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'h1D, 1'b0, 1'b0);
        n_checks++;
        if (key_status !== 6'b0) begin
            n_fail++; $display("FAIL ext_break: got %b expected 000000", key_status);
        end
        send_frame(8'h1C, 1'b0, 1'b0);
        n_checks++;
        if (key_status !== 6'b000010) begin
            n_fail++; $display("FAIL ext_leak: got %b expected 000010", key_status);
        end
    endtask

    task automatic test_timeout();
        int v0, e0;
        v0 = valid_cnt;
        e0 = err_cnt;
        send_bits(make_frame(8'h76, 1'b0, 1'b0), 6);
        repeat (TO + 50) @(negedge clk);
        model_frame(8'h00, 1'b0);
        n_checks++;
        if (err_cnt - e0 !== 1) begin
            n_fail++; $display("FAIL timeout_err: got %0d expected 1", err_cnt - e0);
        end
        n_checks++;
        if (valid_cnt - v0 !== 0) begin
            n_fail++; $display("FAIL timeout_valid: got %0d expected 0", valid_cnt - v0);
        end
        send_frame(8'h76, 1'b0, 1'b0);
        n_checks++;
        if (key_status !== 6'b100010) begin
            n_fail++; $display("FAIL timeout_recover: got %b expected 100010", key_status);
        end
    endtask

    task automatic test_reset_mid();
        int e0;
        e0 = err_cnt;
        send_bits(make_frame(8'h29, 1'b0, 1'b0), 4);
        do_reset(1);
        @(negedge clk);
        n_checks++;
        if (key_status !== 6'b0) begin
            n_fail++; $display("FAIL midreset_keys: got %b expected 000000", key_status);
        end
        send_frame(8'h29, 1'b0, 1'b0);
        n_checks++;
        if (key_status !== 6'b010000) begin
            n_fail++; $display("FAIL midreset_frame: got %b expected 010000", key_status);
        end
        n_checks++;
        if (err_cnt - e0 !== 0) begin
            n_fail++; $display("FAIL midreset_err: got %0d expected 0", err_cnt - e0);
        end
    endtask

    task automatic test_random();
        logic [7:0] pool [8] = '{8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h29, 8'h76, 8'hF0, 8'hE0};
        logic [7:0] b;
        int         sel, fault;
        for (int n = 0; n < 60; n++) begin
            sel = int'($urandom_range(0, 9));
            b   = (sel < 8) ? pool[sel] : 8'($urandom);
            fault = int'($urandom_range(0, 11));
            send_frame(b, fault == 0, fault == 1);
            n_checks++;
            if (key_status !== m_keys) begin
                n_fail++;
                $display("FAIL rand_keys[%0d]: byte %h got %b expected %b", n, b, key_status, m_keys);
            end
            n_checks++;
            if (scan_code !== m_code) begin
                n_fail++;
                $display("FAIL rand_code[%0d]: got %h expected %h", n, scan_code, m_code);
            end
            n_checks++;
            if (valid_cnt !== m_valid) begin
                n_fail++;
                $display("FAIL rand_valid[%0d]: got %0d expected %0d", n, valid_cnt, m_valid);
            end
            n_checks++;
            if (err_cnt !== m_err) begin
                n_fail++;
                $display("FAIL rand_err[%0d]: got %0d expected %0d", n, err_cnt, m_err);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_sequence();
        test_parity_err();
        test_ext();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
